// File: rtl/alu_arbiter.sv
// Two-port arbiter in front of a 4-bit ALU: one operation in flight at a time,
// round-robin or fixed-priority grant, result held until the consumer takes it.
module alu_arbiter #(
    parameter int PRIO_MODE = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0_valid,
    input  logic       req1_valid,
    output logic       req0_ready,
    output logic       req1_ready,
    input  logic [2:0] req0_oc,
    input  logic [2:0] req1_oc,
    input  logic [3:0] req0_a,
    input  logic [3:0] req0_b,
    input  logic [3:0] req1_a,
    input  logic [3:0] req1_b,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic       rsp_id,
    output logic [3:0] rsp_f,
    output logic       rsp_err,
    output logic [7:0] op_count,
    output logic [1:0] dbg_state
);

    // Handshakes: a transfer happens on any rising edge where valid && ready are
    // both high; ready never depends on the same cycle's transfer having happened.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e     state_q, state_d;
    logic [2:0] oc_q, oc_d;
    logic [3:0] a_q, a_d;
    logic [3:0] b_q, b_d;
    logic       id_q, id_d;
    logic       last_grant_q, last_grant_d;
    logic       rsp_valid_q, rsp_valid_d;
    logic [3:0] rsp_f_q, rsp_f_d;
    logic       rsp_err_q, rsp_err_d;
    logic       rsp_id_q, rsp_id_d;
    logic [7:0] op_count_q, op_count_d;

    logic       grant;
    logic       accept;
    logic [3:0] alu_f;
    logic       alu_err;

    // grant names the winning port; with no contest the lone valid port wins
    always_comb begin
        if (req0_valid && req1_valid) begin
            grant = (PRIO_MODE == 1) ? 1'b0 : ~last_grant_q;
        end else begin
            grant = req1_valid;
        end
    end

    assign req0_ready = rst_n && (state_q == IDLE) && req0_valid && !grant;
    assign req1_ready = rst_n && (state_q == IDLE) && req1_valid && grant;
    assign accept     = req0_ready || req1_ready;

    always_comb begin
        alu_f   = 4'h0;
        alu_err = 1'b0;
        case (oc_q)
            3'b000: alu_f = a_q + b_q;
            3'b001: alu_f = a_q - b_q;
            3'b010: alu_f = a_q * b_q;
            3'b011: begin
                if (b_q == 4'h0) begin
                    alu_err = 1'b1;
                end else begin
                    alu_f = a_q / b_q;
                end
            end
            3'b100: alu_f = ~a_q;
            3'b101: alu_f = a_q ^ b_q;
            3'b110: alu_f = a_q | b_q;
            default: alu_f = a_q & b_q;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        oc_d         = oc_q;
        a_d          = a_q;
        b_d          = b_q;
        id_d         = id_q;
        last_grant_d = last_grant_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_f_d      = rsp_f_q;
        rsp_err_d    = rsp_err_q;
        rsp_id_d     = rsp_id_q;
        op_count_d   = op_count_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d      = EXEC;
                    oc_d         = grant ? req1_oc : req0_oc;
                    a_d          = grant ? req1_a  : req0_a;
                    b_d          = grant ? req1_b  : req0_b;
                    id_d         = grant;
                    last_grant_d = grant;
                end
            end
            EXEC: begin
                state_d     = RESP;
                rsp_f_d     = alu_f;
                rsp_err_d   = alu_err;
                rsp_id_d    = id_q;
                rsp_valid_d = 1'b1;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                    op_count_d  = op_count_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // last_grant resets to port 1 so port 0 wins the first contest
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            oc_q         <= 3'h0;
            a_q          <= 4'h0;
            b_q          <= 4'h0;
            id_q         <= 1'b0;
            last_grant_q <= 1'b1;
            rsp_valid_q  <= 1'b0;
            rsp_f_q      <= 4'h0;
            rsp_err_q    <= 1'b0;
            rsp_id_q     <= 1'b0;
            op_count_q   <= 8'h00;
        end else begin
            state_q      <= state_d;
            oc_q         <= oc_d;
            a_q          <= a_d;
            b_q          <= b_d;
            id_q         <= id_d;
            last_grant_q <= last_grant_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_f_q      <= rsp_f_d;
            rsp_err_q    <= rsp_err_d;
            rsp_id_q     <= rsp_id_d;
            op_count_q   <= op_count_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_f     = rsp_f_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_id    = rsp_id_q;
    assign op_count  = op_count_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: a round-robin instance checked through a response
// scoreboard, plus a fixed-priority instance checked inline.
module tb_alu_arbiter;

    logic       clk;
    logic       rst_n;
    logic       req0_valid, req1_valid, req0_ready, req1_ready;
    logic [2:0] req0_oc, req1_oc;
    logic [3:0] req0_a, req0_b, req1_a, req1_b;
    logic       rsp_valid, rsp_ready, rsp_id, rsp_err;
    logic [3:0] rsp_f;
    logic [7:0] op_count;
    logic [1:0] dbg_state;

    logic       p_req0_valid, p_req1_valid, p_req0_ready, p_req1_ready;
    logic       p_rsp_valid, p_rsp_ready, p_rsp_id, p_rsp_err;
    logic [3:0] p_rsp_f;
    logic [7:0] p_op_count;
    logic [1:0] p_dbg_state;

    logic [5:0] exp_q[$];   // {id, err, f}
    logic       last_grant;
    int         n_cmp;
    int         n_err;

    alu_arbiter #(.PRIO_MODE(0)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req1_valid(req1_valid),
        .req0_ready(req0_ready), .req1_ready(req1_ready),
        .req0_oc(req0_oc), .req1_oc(req1_oc),
        .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_f(rsp_f), .rsp_err(rsp_err), .op_count(op_count), .dbg_state(dbg_state)
    );

    alu_arbiter #(.PRIO_MODE(1)) dut_p (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(p_req0_valid), .req1_valid(p_req1_valid),
        .req0_ready(p_req0_ready), .req1_ready(p_req1_ready),
        .req0_oc(req0_oc), .req1_oc(req1_oc),
        .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
        .rsp_valid(p_rsp_valid), .rsp_ready(p_rsp_ready), .rsp_id(p_rsp_id),
        .rsp_f(p_rsp_f), .rsp_err(p_rsp_err), .op_count(p_op_count), .dbg_state(p_dbg_state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // returns {err, f}
    function automatic logic [4:0] alu_model(input logic [2:0] oc, input logic [3:0] a, input logic [3:0] b);
        int r;
        int ia;
        int ib;
        ia = int'(a);
        ib = int'(b);
        case (oc)
            3'd0: r = ia + ib;
            3'd1: r = ia - ib;
            3'd2: r = ia * ib;
            3'd3: begin
                if (ib == 0) return 5'b1_0000;
                r = ia / ib;
            end
            3'd4: r = 15 - ia;
            3'd5: r = int'(a ^ b);
            3'd6: r = int'(a | b);
            default: r = int'(a & b);
        endcase
        return {1'b0, 4'(r & 15)};
    endfunction

    // advance to the next falling edge and run the response scoreboard there
    task automatic tick();
        logic [5:0] exp;
        @(negedge clk);
        if (rst_n && rsp_valid && rsp_ready) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL sb_unexpected got id=%0d err=%0d f=%0d required=no response", rsp_id, rsp_err, rsp_f);
            end else begin
                exp = exp_q.pop_front();
                if ({rsp_id, rsp_err, rsp_f} !== exp) begin
                    n_err++;
                    $display("FAIL sb_result got id=%0d err=%0d f=%0d required id=%0d err=%0d f=%0d",
                             rsp_id, rsp_err, rsp_f, exp[5], exp[4], exp[3:0]);
                end
            end
        end
    endtask

    task automatic drive_step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic port, input logic [2:0] oc, input logic [3:0] a, input logic [3:0] b);
        bit got;
        got = 0;
        if (port == 1'b0) begin
            req0_valid = 1'b1; req0_oc = oc; req0_a = a; req0_b = b;
        end else begin
            req1_valid = 1'b1; req1_oc = oc; req1_a = a; req1_b = b;
        end
        for (int i = 0; i < 50 && !got; i++) begin
            tick();
            if ((port == 1'b0 && req0_ready) || (port == 1'b1 && req1_ready)) got = 1;
        end
        if (!got) begin
            n_cmp++;
            n_err++;
            $display("FAIL send_timeout port=%0d got ready=0 required ready=1", port);
        end else begin
            exp_q.push_back({port, alu_model(oc, a, b)});
            last_grant = port;
        end
        drive_step();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 30 && exp_q.size() != 0; i++) tick();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain_timeout got pending=%0d required pending=0", exp_q.size());
            exp_q.delete();
        end
        drive_step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req0_valid = 1'b1; req1_valid = 1'b1;
        p_req0_valid = 1'b1; p_req1_valid = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({req0_ready, req1_ready, p_req0_ready, p_req1_ready} !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_ready got %b required 0000", {req0_ready, req1_ready, p_req0_ready, p_req1_ready});
        end
        n_cmp++;
        if ({rsp_valid, rsp_id, rsp_err, rsp_f, op_count, dbg_state} !== 17'd0) begin
            n_err++;
            $display("FAIL reset_outputs got v=%0d id=%0d err=%0d f=%0d cnt=%0d st=%0d required all 0",
                     rsp_valid, rsp_id, rsp_err, rsp_f, op_count, dbg_state);
        end
        n_cmp++;
        if ({p_rsp_valid, p_rsp_id, p_rsp_err, p_rsp_f, p_op_count, p_dbg_state} !== 17'd0) begin
            n_err++;
            $display("FAIL reset_outputs_prio got v=%0d cnt=%0d st=%0d required all 0", p_rsp_valid, p_op_count, p_dbg_state);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        p_req0_valid = 1'b0; p_req1_valid = 1'b0;
        #2 rst_n = 1'b1;
        last_grant = 1'b1;
        drive_step();
    endtask

    task automatic test_add();
        req0_valid = 1'b1; req0_oc = 3'd0; req0_a = 4'd9; req0_b = 4'd8;
        tick();
        n_cmp++;
        if ({req1_ready, req0_ready} !== 2'b01) begin
            n_err++;
            $display("FAIL add_accept got ready1,0=%b required 01", {req1_ready, req0_ready});
        end
        exp_q.push_back({1'b0, alu_model(3'd0, 4'd9, 4'd8)});
        last_grant = 1'b0;
        drive_step();
        req0_valid = 1'b0;
        tick();
        n_cmp++;
        if (rsp_valid !== 1'b0) begin
            n_err++;
            $display("FAIL add_exec_valid got %0d required 0", rsp_valid);
        end
        tick();
        n_cmp++;
        if ({rsp_valid, rsp_id, rsp_err, rsp_f} !== {1'b1, 1'b0, 1'b0, 4'd1}) begin
            n_err++;
            $display("FAIL add_result got v=%0d id=%0d err=%0d f=%0d required v=1 id=0 err=0 f=1",
                     rsp_valid, rsp_id, rsp_err, rsp_f);
        end
        drive_step();
        tick();
        n_cmp++;
        if ({rsp_valid, op_count} !== {1'b0, 8'd1}) begin
            n_err++;
            $display("FAIL add_count got v=%0d cnt=%0d required v=0 cnt=1", rsp_valid, op_count);
        end
        drive_step();
    endtask

    task automatic test_div();
        send(1'b1, 3'd3, 4'd7, 4'd0);
        drain();
        send(1'b1, 3'd3, 4'd7, 4'd2);
        drain();
    endtask

    task automatic test_round_robin();
        int   grants;
        logic exp_g;
        grants = 0;
        req0_oc = 3'($urandom_range(0, 7)); req0_a = 4'($urandom_range(0, 15)); req0_b = 4'($urandom_range(0, 15));
        req1_oc = 3'($urandom_range(0, 7)); req1_a = 4'($urandom_range(0, 15)); req1_b = 4'($urandom_range(0, 15));
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        for (int cyc = 0; cyc < 60 && grants < 8; cyc++) begin
            tick();
            if (req0_ready || req1_ready) begin
                exp_g = ~last_grant;
                n_cmp++;
                if ({req1_ready, req0_ready} !== (exp_g ? 2'b10 : 2'b01)) begin
                    n_err++;
                    $display("FAIL rr_grant n=%0d got ready1,0=%b required port %0d", grants, {req1_ready, req0_ready}, exp_g);
                end
                if (exp_g) exp_q.push_back({1'b1, alu_model(req1_oc, req1_a, req1_b)});
                else       exp_q.push_back({1'b0, alu_model(req0_oc, req0_a, req0_b)});
                last_grant = exp_g;
                grants++;
                drive_step();
                if (exp_g) begin
                    req1_oc = 3'($urandom_range(0, 7)); req1_a = 4'($urandom_range(0, 15)); req1_b = 4'($urandom_range(0, 15));
                end else begin
                    req0_oc = 3'($urandom_range(0, 7)); req0_a = 4'($urandom_range(0, 15)); req0_b = 4'($urandom_range(0, 15));
                end
            end
        end
        n_cmp++;
        if (grants != 8) begin
            n_err++;
            $display("FAIL rr_count got %0d grants required 8", grants);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        drain();
    endtask

    task automatic test_prio();
        int accepts;
        accepts = 0;
        req0_oc = 3'd0; req0_a = 4'd9; req0_b = 4'd8;
        req1_oc = 3'd7; req1_a = 4'd15; req1_b = 4'd15;
        p_rsp_ready = 1'b1;
        p_req0_valid = 1'b1;
        p_req1_valid = 1'b1;
        for (int cyc = 0; cyc < 30; cyc++) begin
            tick();
            n_cmp++;
            if (p_req1_ready !== 1'b0) begin
                n_err++;
                $display("FAIL prio_grant cyc=%0d got port1 ready=%0d required 0", cyc, p_req1_ready);
            end
            if (p_req0_ready) accepts++;
            if (p_rsp_valid) begin
                n_cmp++;
                if ({p_rsp_id, p_rsp_err, p_rsp_f} !== {1'b0, 1'b0, 4'd1}) begin
                    n_err++;
                    $display("FAIL prio_result got id=%0d err=%0d f=%0d required id=0 err=0 f=1", p_rsp_id, p_rsp_err, p_rsp_f);
                end
            end
        end
        drive_step();
        p_req0_valid = 1'b0;
        p_req1_valid = 1'b0;
        tick();
        n_cmp++;
        if (accepts != 10 || p_op_count !== 8'd10) begin
            n_err++;
            $display("FAIL prio_count got accepts=%0d cnt=%0d required 10/10", accepts, p_op_count);
        end
        drive_step();
    endtask

    task automatic test_backpressure();
        logic exp_g;
        rsp_ready = 1'b0;
        send(1'b0, 3'd5, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
        req0_oc = 3'($urandom_range(0, 7)); req0_a = 4'($urandom_range(0, 15)); req0_b = 4'($urandom_range(0, 15));
        req1_oc = 3'($urandom_range(0, 7)); req1_a = 4'($urandom_range(0, 15)); req1_b = 4'($urandom_range(0, 15));
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) begin
            tick();
            n_cmp++;
            if ({rsp_valid, rsp_id, rsp_err, rsp_f, req0_ready, req1_ready} !== {1'b1, exp_q[0], 2'b00}) begin
                n_err++;
                $display("FAIL bp_hold i=%0d got v=%0d id=%0d err=%0d f=%0d rdy=%b%b required v=1 rsp=%h rdy=00",
                         i, rsp_valid, rsp_id, rsp_err, rsp_f, req1_ready, req0_ready, exp_q[0]);
            end
        end
        drive_step();
        rsp_ready = 1'b1;
        tick();
        n_cmp++;
        if ({req1_ready, req0_ready} !== 2'b00) begin
            n_err++;
            $display("FAIL bp_handshake_ready got %b required 00", {req1_ready, req0_ready});
        end
        drive_step();
        tick();
        exp_g = ~last_grant;
        n_cmp++;
        if ({req1_ready, req0_ready} !== (exp_g ? 2'b10 : 2'b01)) begin
            n_err++;
            $display("FAIL bp_next_accept got %b required port %0d", {req1_ready, req0_ready}, exp_g);
        end
        if (exp_g) exp_q.push_back({1'b1, alu_model(req1_oc, req1_a, req1_b)});
        else       exp_q.push_back({1'b0, alu_model(req0_oc, req0_a, req0_b)});
        last_grant = exp_g;
        drive_step();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        drain();
    endtask

    task automatic test_reset_mid();
        send(1'b0, 3'd2, 4'd5, 4'd5);
        req0_valid = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({rsp_valid, rsp_id, rsp_err, rsp_f, op_count, dbg_state, req0_ready, req1_ready} !== 19'd0) begin
            n_err++;
            $display("FAIL rst_mid_outputs got v=%0d id=%0d err=%0d f=%0d cnt=%0d st=%0d rdy=%b%b required all 0",
                     rsp_valid, rsp_id, rsp_err, rsp_f, op_count, dbg_state, req1_ready, req0_ready);
        end
        exp_q.delete();
        last_grant = 1'b1;
        req0_valid = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            n_cmp++;
            if (rsp_valid !== 1'b0) begin
                n_err++;
                $display("FAIL rst_mid_no_rsp i=%0d got v=%0d required 0", i, rsp_valid);
            end
        end
        drive_step();
    endtask

    task automatic test_wrap_arith();
        send(1'b0, 3'd2, 4'd5, 4'd5);
        drain();
        send(1'b1, 3'd1, 4'd2, 4'd3);
        drain();
        for (int done = 3; done <= 256; done++) begin
            send(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
            drain();
            if (done == 255 || done == 256) begin
                n_cmp++;
                if (op_count !== 8'(done)) begin
                    n_err++;
                    $display("FAIL op_count_wrap done=%0d got %0d required %0d", done, op_count, 8'(done));
                end
            end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_oc = 3'd0; req1_oc = 3'd0;
        req0_a = 4'd0; req0_b = 4'd0; req1_a = 4'd0; req1_b = 4'd0;
        rsp_ready = 1'b1;
        p_req0_valid = 1'b0; p_req1_valid = 1'b0; p_rsp_ready = 1'b1;
        last_grant = 1'b1;
        test_reset();
        test_add();
        test_div();
        test_round_robin();
        test_prio();
        test_backpressure();
        test_reset_mid();
        test_wrap_arith();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
